// File: rtl/mips_defs.sv
// Shared MIPS definitions: memory opcodes, byte-enable constants and the MEM/WB payload.
package mips_defs;

  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 26;

  typedef logic [5:0] opcode_t;

  localparam opcode_t LW  = 6'b100011;
  localparam opcode_t LH  = 6'b100001;
  localparam opcode_t LHU = 6'b100101;
  localparam opcode_t LB  = 6'b100000;
  localparam opcode_t LBU = 6'b100100;
  localparam opcode_t SW  = 6'b101011;
  localparam opcode_t SH  = 6'b101001;
  localparam opcode_t SB  = 6'b101000;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  addrLow;
    logic [31:0] dmData;
    logic        alignErr;
  } memWb_t;

  function automatic opcode_t opOf(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/store_be_gen.sv
// Store byte-lane decode and data replication, plus load/store misalignment detection.
module store_be_gen
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addrLow,
  input  logic [31:0] wData,
  output logic [3:0]  BE,
  output logic [31:0] WDataAligned,
  output logic        AlignErr
);

  always_comb begin
    BE           = BE_NONE;
    WDataAligned = wData;
    AlignErr     = 1'b0;
    case (op)
      SW: begin
        if (addrLow == 2'b00) BE = BE_WORD;
        else                  AlignErr = 1'b1;
      end
      SH: begin
        WDataAligned = {2{wData[15:0]}};
        if (addrLow[0]) AlignErr = 1'b1;
        else            BE = addrLow[1] ? 4'b1100 : 4'b0011;
      end
      SB: begin
        WDataAligned = {4{wData[7:0]}};
        BE           = 4'b0001 << addrLow;
      end
      LW:      AlignErr = (addrLow != 2'b00);
      LH, LHU: AlignErr = addrLow[0];
      LB, LBU: AlignErr = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_mem_stage.sv
// MEM stage: byte-enabled word RAM with synchronous read-before-write and the MEM/WB register.
module dm_mem_stage
  import mips_defs::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic        Clr,
  input  logic [31:0] InstrM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WDataM,
  output logic [31:0] InstrW,
  output logic [1:0]  AddrLowW,
  output logic [31:0] DMDataW,
  output logic        AlignErrW
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        be;
  logic [31:0]       wAligned;
  logic              alignErr;
  memWb_t            wReg;

  // Upper address bits intentionally ignored so out-of-range addresses wrap.
  logic unusedAddrHi;
  assign unusedAddrHi = ^AddrM[31:ADDR_W+2];

  assign idx = AddrM[ADDR_W+1:2];

  store_be_gen uBeGen (
    .op           (opOf(InstrM)),
    .addrLow      (AddrM[1:0]),
    .wData        (WDataM),
    .BE           (be),
    .WDataAligned (wAligned),
    .AlignErr     (alignErr)
  );

  // Reset clears the whole RAM; stall holds everything; Clr inserts a bubble and drops the store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wReg <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
    end else if (En) begin
      if (Clr) begin
        wReg <= '0;
      end else begin
        wReg.instr    <= InstrM;
        wReg.addrLow  <= AddrM[1:0];
        wReg.dmData   <= mem[idx];
        wReg.alignErr <= alignErr;
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wAligned[8*b +: 8];
        end
      end
    end
  end

  assign InstrW    = wReg.instr;
  assign AddrLowW  = wReg.addrLow;
  assign DMDataW   = wReg.dmData;
  assign AlignErrW = wReg.alignErr;

endmodule

// File: tb/tb_dm_mem_stage.sv
// Scoreboard bench for dm_mem_stage: reference memory model predicts each WB-stage output.
module tb_dm_mem_stage;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  addrLow;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        En;
  logic        Clr;
  logic [31:0] InstrM;
  logic [31:0] AddrM;
  logic [31:0] WDataM;
  logic [31:0] InstrW;
  logic [1:0]  AddrLowW;
  logic [31:0] DMDataW;
  logic        AlignErrW;

  int nVec;
  int nErr;

  logic [31:0] mdl [1024];
  exp_t        last;
  exp_t        sb [$];

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_ADD = 6'b000000;

  dm_mem_stage #(.ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .En        (En),
    .Clr       (Clr),
    .InstrM    (InstrM),
    .AddrM     (AddrM),
    .WDataM    (WDataM),
    .InstrW    (InstrW),
    .AddrLowW  (AddrLowW),
    .DMDataW   (DMDataW),
    .AlignErrW (AlignErrW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0a5_1234};
  endfunction

  // Reference model of one clock edge, applied after the edge has happened.
  task automatic model(input logic rst, en, clr, input logic [31:0] ins, addr, wd);
    logic [9:0]  w;
    logic [5:0]  op;
    logic        err;
    logic [31:0] word;
    exp_t        e;
    w  = addr[11:2];
    op = ins[31:26];
    if (!rst) begin
      for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
      e = '{32'h0, 2'b00, 32'h0, 1'b0};
    end else if (!en) begin
      e = last;
    end else if (clr) begin
      e = '{32'h0, 2'b00, 32'h0, 1'b0};
    end else begin
      word = mdl[w];
      err  = 1'b0;
      if (op == OP_SW) begin
        if (addr[1:0] == 2'b00) word = wd;
        else err = 1'b1;
      end else if (op == OP_SH) begin
        if (addr[0]) err = 1'b1;
        else if (addr[1]) word[31:16] = wd[15:0];
        else word[15:0] = wd[15:0];
      end else if (op == OP_SB) begin
        case (addr[1:0])
          2'd0: word[7:0]   = wd[7:0];
          2'd1: word[15:8]  = wd[7:0];
          2'd2: word[23:16] = wd[7:0];
          default: word[31:24] = wd[7:0];
        endcase
      end else if (op == OP_LW) begin
        err = (addr[1:0] != 2'b00);
      end else if (op == OP_LH || op == OP_LHU) begin
        err = addr[0];
      end
      e = '{ins, addr[1:0], mdl[w], err};
      mdl[w] = word;
    end
    last = e;
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic rst, en, clr,
                      input logic [31:0] ins, addr, wd);
    exp_t e;
    @(negedge clk);
    reset  = rst;
    En     = en;
    Clr    = clr;
    InstrM = ins;
    AddrM  = addr;
    WDataM = wd;
    @(posedge clk);
    model(rst, en, clr, ins, addr, wd);
    #1;
    if (sb.size() == 0) begin
      nVec++;
      nErr++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".instr"}, InstrW, e.instr);
      check({tag, ".alow"}, {30'h0, AddrLowW}, {30'h0, e.addrLow});
      check({tag, ".data"}, DMDataW, e.data);
      check({tag, ".aerr"}, {31'h0, AlignErrW}, {31'h0, e.err});
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    nVec   = 0;
    nErr   = 0;
    reset  = 1'b0;
    En     = 1'b0;
    Clr    = 1'b0;
    InstrM = '0;
    AddrM  = '0;
    WDataM = '0;
    last   = '{32'h0, 2'b00, 32'h0, 1'b0};

    // Reset and reads of cleared RAM
    step("reset",  1'b0, 1'b1, 1'b0, mk(OP_SW), 32'h0, 32'hFFFF_FFFF);
    step("lw0",    1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h0,   32'h0);
    step("lw3fc",  1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h3FC, 32'h0);

    // Word store, then partial stores
    step("sw10",   1'b1, 1'b1, 1'b0, mk(OP_SW), 32'h10, 32'h1122_3344);
    step("lw10",   1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h10, 32'h0);
    step("sb12",   1'b1, 1'b1, 1'b0, mk(OP_SB), 32'h12, 32'h0000_00AB);
    step("lw10b",  1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h10, 32'h0);
    step("sh10",   1'b1, 1'b1, 1'b0, mk(OP_SH), 32'h10, 32'h0000_BEEF);
    step("lw10h",  1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h10, 32'h0);

    // Misaligned accesses
    step("sw13",   1'b1, 1'b1, 1'b0, mk(OP_SW), 32'h13, 32'hDEAD_DEAD);
    step("lh11",   1'b1, 1'b1, 1'b0, mk(OP_LH), 32'h11, 32'h0);
    step("sh11",   1'b1, 1'b1, 1'b0, mk(OP_SH), 32'h11, 32'h0000_5555);
    step("lw12",   1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h12, 32'h0);
    step("lhu12",  1'b1, 1'b1, 1'b0, mk(OP_LHU), 32'h12, 32'h0);

    // Stall with a pending store, then release
    for (int i = 0; i < 3; i++)
      step("stall", 1'b1, 1'b0, 1'b0, mk(OP_SW), 32'h20, 32'h5555_AAAA);
    step("swrel",  1'b1, 1'b1, 1'b0, mk(OP_SW), 32'h20, 32'h5555_AAAA);
    step("lw20",   1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h20, 32'h0);

    // Flushed store must not write
    step("clrsw",  1'b1, 1'b1, 1'b1, mk(OP_SW), 32'h24, 32'h7777_7777);
    step("lw24",   1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h24, 32'h0);
    step("clrhld", 1'b1, 1'b0, 1'b1, mk(OP_SW), 32'h28, 32'h1);

    // Address wrap and read-before-write ordering
    step("sw1000", 1'b1, 1'b1, 1'b0, mk(OP_SW), 32'h1000, 32'hCAFE_F00D);
    step("lw0w",   1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h0, 32'h0);
    step("sw40",   1'b1, 1'b1, 1'b0, mk(OP_SW), 32'h40, 32'h1234_5678);
    step("lw40",   1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h40, 32'h0);
    step("sw40b",  1'b1, 1'b1, 1'b0, mk(OP_SW), 32'h40, 32'h9ABC_DEF0);
    step("alu",    1'b1, 1'b1, 1'b0, mk(OP_ADD), 32'h40, 32'h0);

    // Randomised mix over a small address window
    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_SW, OP_SH, OP_SB, OP_ADD};
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 7)];
      step("rnd", 1'b1, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
           mk(op), 32'h80 + 32'($urandom_range(0, 31)), $urandom);
    end

    // Mid-run reset wipes the RAM
    step("rst2",   1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h10, 32'h0);
    step("lw10r",  1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h10, 32'h0);
    step("lw40r",  1'b1, 1'b1, 1'b0, mk(OP_LW), 32'h40, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
